// File: rtl/mha_pkg.sv
// Shared constants and types for the MHA score path: base-2 exponent
// approximation constants and the exp_sum sequencer states.
package mha_pkg;

  localparam int ROW_LEN   = 16;
  localparam int LOG2E_Q12 = 5909;

  // round(2^(i/16) * 32768), indexed by the top four fraction bits
  localparam logic [16:0] EXP2_LUT [0:15] = '{
    17'd32768, 17'd34219, 17'd35734, 17'd37316,
    17'd38968, 17'd40693, 17'd42495, 17'd44376,
    17'd46341, 17'd48393, 17'd50535, 17'd52773,
    17'd55109, 17'd57549, 17'd60097, 17'd62757
  };

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

endpackage

// File: rtl/exp_sum_exp2_unit.sv
// Combinational e^diff approximation for diff <= 0: converts to base 2,
// splits integer/fraction, looks up 2^frac and shifts by the integer part.
module exp2_unit
  import mha_pkg::*;
#(
  parameter int D_W  = 16,
  parameter int FRAC = 8
) (
  input  logic signed [D_W:0]   I_DIFF,
  output logic        [D_W-1:0] O_E
);

  localparam int P_W = D_W + 14;
  localparam logic signed [P_W-1:0] LOG2E_S = P_W'(LOG2E_Q12);

  logic signed [D_W:0]   diff_clamped;
  logic signed [P_W-1:0] diff_ext;
  logic signed [P_W-1:0] prod;
  logic signed [P_W-1:0] t_val;
  logic signed [P_W-1:0] n_val;
  logic        [P_W-1:0] shift_amt;
  logic        [3:0]     lut_idx;
  logic        [16:0]    mant;

  // A positive difference only arises from a malformed max; treat it as 0.
  always_comb begin
    diff_clamped = I_DIFF[D_W] ? I_DIFF : '0;
    diff_ext     = P_W'(diff_clamped);
    prod         = diff_ext * LOG2E_S;
    t_val        = prod >>> 12;
    n_val        = t_val >>> FRAC;
    shift_amt    = -n_val;
    lut_idx      = t_val[FRAC-1 -: 4];
    mant         = EXP2_LUT[lut_idx] >> (15 - FRAC);
    if (shift_amt > P_W'(FRAC)) begin
      O_E = '0;
    end else begin
      O_E = D_W'(mant >> shift_amt[4:0]);
    end
  end

endmodule

// File: rtl/exp_sum.sv
// Softmax numerator stage: evaluates e^(x - max) for one score element per
// clock and accumulates the row sum, publishing all 16 values at row end.
module exp_sum
  import mha_pkg::*;
#(
  parameter int D_W  = 16,
  parameter int FRAC = 8
) (
  input  logic                  I_CLK,
  input  logic                  I_RST_N,
  input  logic                  I_ENA,
  input  logic signed [D_W-1:0] I_DATA [0:ROW_LEN-1],
  input  logic signed [D_W-1:0] I_MAX,
  output logic                  O_BUSY,
  output logic                  O_VLD,
  output logic        [D_W-1:0] O_EXP  [0:ROW_LEN-1],
  output logic        [D_W+3:0] O_SUM
);

  state_t                state_q, state_d;
  logic        [3:0]     idx_q, idx_d;
  logic        [D_W+3:0] acc_q, acc_d;
  logic signed [D_W-1:0] row_q  [0:ROW_LEN-1];
  logic signed [D_W-1:0] row_d  [0:ROW_LEN-1];
  logic signed [D_W-1:0] max_q, max_d;
  logic        [D_W-1:0] ebuf_q [0:ROW_LEN-1];
  logic        [D_W-1:0] ebuf_d [0:ROW_LEN-1];
  logic        [D_W-1:0] exp_q  [0:ROW_LEN-1];
  logic        [D_W-1:0] exp_d  [0:ROW_LEN-1];
  logic        [D_W+3:0] sum_q, sum_d;
  logic                  vld_q, vld_d;

  logic signed [D_W:0]   diff;
  logic        [D_W-1:0] e_val;

  // One extra bit so row minus max cannot overflow.
  assign diff = {row_q[idx_q][D_W-1], row_q[idx_q]} - {max_q[D_W-1], max_q};

  exp2_unit #(
    .D_W  (D_W),
    .FRAC (FRAC)
  ) u_exp2 (
    .I_DIFF (diff),
    .O_E    (e_val)
  );

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (I_ENA) state_d = S_CALC;
      S_CALC:  if (idx_q == 4'd15) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    acc_d  = acc_q;
    row_d  = row_q;
    max_d  = max_q;
    ebuf_d = ebuf_q;
    exp_d  = exp_q;
    sum_d  = sum_q;
    vld_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (I_ENA) begin
        row_d = I_DATA;
        max_d = I_MAX;
        idx_d = '0;
        acc_d = '0;
      end
    end else begin
      ebuf_d[idx_q] = e_val;
      acc_d         = acc_q + (D_W+4)'(e_val);
      idx_d         = idx_q + 4'd1;
      // Last element: publish the buffer and sum including this element.
      if (idx_q == 4'd15) begin
        exp_d = ebuf_d;
        sum_d = acc_d;
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      idx_q  <= '0;
      acc_q  <= '0;
      row_q  <= '{default: '0};
      max_q  <= '0;
      ebuf_q <= '{default: '0};
      exp_q  <= '{default: '0};
      sum_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      acc_q  <= acc_d;
      row_q  <= row_d;
      max_q  <= max_d;
      ebuf_q <= ebuf_d;
      exp_q  <= exp_d;
      sum_q  <= sum_d;
      vld_q  <= vld_d;
    end
  end

  always_comb begin
    O_BUSY = (state_q != S_IDLE);
    O_VLD  = vld_q;
    O_EXP  = exp_q;
    O_SUM  = sum_q;
  end

endmodule

// File: tb/tb_exp_sum.sv
// Self-checking bench for exp_sum: directed and random rows compared against
// an arithmetic model of e^(x - max), plus latency, back-to-back and reset.
module tb_exp_sum;

  localparam int D_W  = 16;
  localparam int FRAC = 8;

  logic                  I_CLK   = 1'b0;
  logic                  I_RST_N = 1'b0;
  logic                  I_ENA   = 1'b0;
  logic signed [D_W-1:0] I_DATA [0:15];
  logic signed [D_W-1:0] I_MAX;
  logic                  O_BUSY;
  logic                  O_VLD;
  logic        [D_W-1:0] O_EXP [0:15];
  logic        [D_W+3:0] O_SUM;

  int     checks = 0;
  int     passed = 0;
  longint cycle_cnt = 0;
  longint vld_cycle = 0;

  logic signed [D_W-1:0] stim_data [0:15];
  logic signed [D_W-1:0] stim_max;
  longint                exp_e [0:15];
  longint                exp_total;

  longint lut [0:15] = '{32768, 34219, 35734, 37316, 38968, 40693, 42495, 44376,
                         46341, 48393, 50535, 52773, 55109, 57549, 60097, 62757};

  exp_sum #(
    .D_W  (D_W),
    .FRAC (FRAC)
  ) dut (
    .I_CLK   (I_CLK),
    .I_RST_N (I_RST_N),
    .I_ENA   (I_ENA),
    .I_DATA  (I_DATA),
    .I_MAX   (I_MAX),
    .O_BUSY  (O_BUSY),
    .O_VLD   (O_VLD),
    .O_EXP   (O_EXP),
    .O_SUM   (O_SUM)
  );

  always #5 I_CLK = ~I_CLK;

  always @(posedge I_CLK) cycle_cnt <= cycle_cnt + 1;

  function automatic longint floorDiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // e^(x - max) via 2^(diff*log2e): integer part shifts, top fraction bits index the table.
  function automatic longint modelExp(input longint x, input longint mx);
    longint d, t, n, f, m;
    d = x - mx;
    if (d > 0) d = 0;
    t = floorDiv(d * 5909, 4096);
    n = floorDiv(t, 1 << FRAC);
    f = t - n * (1 << FRAC);
    m = lut[f / (1 << (FRAC - 4))] / (1 << (15 - FRAC));
    if (-n > FRAC) return 0;
    return m >> (-n);
  endfunction

  task automatic checkOutput(input string tag, input longint obs, input longint expv);
    checks++;
    if (obs == expv) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
  endtask

  task automatic fillRow(input logic signed [D_W-1:0] val, input logic signed [D_W-1:0] mx);
    for (int k = 0; k < 16; k++) stim_data[k] = val;
    stim_max = mx;
  endtask

  task automatic fillRandomRow();
    int base;
    base = int'($urandom_range(0, 20000)) - 10000;
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 7) == 0) stim_data[k] = D_W'(base + int'($urandom_range(1, 300)));
      else                           stim_data[k] = D_W'(base - int'($urandom_range(0, 2500)));
    end
    stim_max = D_W'(base);
  endtask

  // Called at a negedge: pulses I_ENA for one edge, then scrambles the inputs.
  task automatic applyStimulus();
    exp_total = 0;
    for (int k = 0; k < 16; k++) begin
      exp_e[k]   = modelExp(longint'(stim_data[k]), longint'(stim_max));
      exp_total += exp_e[k];
    end
    I_DATA = stim_data;
    I_MAX  = stim_max;
    I_ENA  = 1'b1;
    @(negedge I_CLK);
    I_ENA = 1'b0;
    for (int k = 0; k < 16; k++) I_DATA[k] = D_W'($urandom);
    I_MAX = D_W'($urandom);
  endtask

  task automatic waitResult(input string tag, input bit mid_ena);
    int lat;
    int busy_low;
    bit seen;
    lat      = 0;
    busy_low = 0;
    seen     = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge I_CLK);
      @(negedge I_CLK);
      lat++;
      if (mid_ena) begin
        if (lat == 5) begin
          I_ENA = 1'b1;
          for (int k = 0; k < 16; k++) I_DATA[k] = 16'sh7fff;
          I_MAX = 16'sh8000;
        end else begin
          I_ENA = 1'b0;
        end
      end
      if (O_VLD) seen = 1'b1;
      else if (!O_BUSY) busy_low++;
    end
    I_ENA = 1'b0;
    checkOutput({tag, "_seen"}, longint'(seen), 1);
    if (!seen) return;
    vld_cycle = cycle_cnt;
    checkOutput({tag, "_latency"}, lat, 16);
    checkOutput({tag, "_busy_during"}, busy_low, 0);
    checkOutput({tag, "_busy_at_vld"}, longint'(O_BUSY), 0);
    for (int k = 0; k < 16; k++)
      checkOutput($sformatf("%s_exp%0d", tag, k), longint'(O_EXP[k]), exp_e[k]);
    checkOutput({tag, "_sum"}, longint'(O_SUM), exp_total);
  endtask

  initial begin
    longint first_vld;
    int     vld_seen;
    I_DATA = '{default: '0};
    I_MAX  = '0;
    #1;
    checkOutput("rst_busy", longint'(O_BUSY), 0);
    checkOutput("rst_vld",  longint'(O_VLD), 0);
    checkOutput("rst_sum",  longint'(O_SUM), 0);
    checkOutput("rst_exp0", longint'(O_EXP[0]), 0);
    checkOutput("rst_exp15", longint'(O_EXP[15]), 0);
    repeat (2) @(negedge I_CLK);
    I_RST_N = 1'b1;
    @(negedge I_CLK);

    fillRow(16'sh0100, 16'sh0100);
    applyStimulus();
    waitResult("flat", 1'b0);
    checkOutput("flat_sum_const", longint'(O_SUM), 4096);
    @(negedge I_CLK);
    checkOutput("flat_pulse_end", longint'(O_VLD), 0);
    checkOutput("flat_hold_sum", longint'(O_SUM), 4096);

    fillRow(16'sh8000, 16'sh0000);
    stim_data[0] = 16'sh0000;
    applyStimulus();
    waitResult("sparse", 1'b0);
    checkOutput("sparse_sum_const", longint'(O_SUM), 256);

    fillRow(-16'sd256, 16'sh0000);
    applyStimulus();
    waitResult("neg_one", 1'b0);
    checkOutput("neg_one_exp_const", longint'(O_EXP[7]), 90);
    checkOutput("neg_one_sum_const", longint'(O_SUM), 1440);

    fillRow(16'sh0100, 16'sh0100);
    stim_data[3] = 16'sh0200;
    applyStimulus();
    waitResult("clamp", 1'b0);
    checkOutput("clamp_exp3_const", longint'(O_EXP[3]), 256);

    for (int k = 0; k < 16; k++) stim_data[k] = k[0] ? 16'sh8000 : 16'sh7fff;
    stim_max = 16'sh7fff;
    applyStimulus();
    waitResult("extreme", 1'b0);

    fillRandomRow();
    applyStimulus();
    waitResult("b2b_a", 1'b1);
    first_vld = vld_cycle;
    fillRandomRow();
    applyStimulus();
    waitResult("b2b_b", 1'b0);
    checkOutput("b2b_period", vld_cycle - first_vld, 17);
    @(negedge I_CLK);

    for (int r = 0; r < 5; r++) begin
      fillRandomRow();
      applyStimulus();
      waitResult($sformatf("rand%0d", r), 1'b0);
      @(negedge I_CLK);
    end

    fillRow(16'sh0100, 16'sh0100);
    applyStimulus();
    waitResult("pre_rst", 1'b0);
    @(negedge I_CLK);
    fillRow(16'sh0000, 16'sh0000);
    applyStimulus();
    repeat (8) @(posedge I_CLK);
    I_RST_N = 1'b0;
    #1;
    checkOutput("midrst_busy", longint'(O_BUSY), 0);
    checkOutput("midrst_vld",  longint'(O_VLD), 0);
    checkOutput("midrst_sum",  longint'(O_SUM), 0);
    checkOutput("midrst_exp0", longint'(O_EXP[0]), 0);
    @(negedge I_CLK);
    I_RST_N  = 1'b1;
    vld_seen = 0;
    repeat (20) begin
      @(negedge I_CLK);
      if (O_VLD) vld_seen++;
    end
    checkOutput("midrst_no_vld", vld_seen, 0);
    fillRandomRow();
    applyStimulus();
    waitResult("post_rst", 1'b0);

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/exp_sum.md
# exp_sum

Softmax numerator stage of the MHA score path. Takes a 16-element signed score row plus its row maximum (from the max-select stage, O_MAX/O_VLD), computes e^(x−max) per element with a base-2 shift/LUT approximation, and accumulates the row sum. Evaluates one element per clock. Hands 16 exponent values plus their sum to the downstream normalise/divide stage.

## Interface
- D_W, 16, score/exponent data width
- FRAC, 8, fractional bits of scores and exponents; legal range 4..D_W−2
- I_CLK  in  1  clock
- I_RST_N  in  1  reset: asynchronous, active-low; clock I_CLK
- I_ENA  in  1  start pulse; sampled only in S_IDLE
- I_DATA  in  D_W×[0:15]  signed scores, Q(D_W−FRAC).FRAC
- I_MAX  in  D_W  signed row maximum, same format
- O_BUSY  out  1  high while not in S_IDLE
- O_VLD  out  1  one-cycle result-valid pulse
- O_EXP  out  D_W×[0:15]  unsigned exponents; 1.0 = 1<<FRAC
- O_SUM  out  D_W+4  unsigned sum of O_EXP

## Operation
- States: S_IDLE, S_CALC.
  - S_IDLE + I_ENA: latch I_DATA/I_MAX into row/max regs; idx←0; acc←0; go to S_CALC.
  - S_CALC: process element idx each cycle.
    - idx<15: stay in S_CALC, idx++.
    - idx==15: go to S_IDLE.
- Per element:
  - Difference: diff = row[idx] − max, computed at D_W+1 bits signed.
  - Clamping: diff>0 (malformed max) is clamped to 0.
  - t = (diff × LOG2E_Q12) >>> 12, arithmetic shift (floor).
  - n = t >>> FRAC (integer part, ≤0).
  - f = t[FRAC−1:0].
  - Mantissa: m = EXP2_LUT[f[FRAC−1:FRAC−4]] >> (15−FRAC).
  - Result: e = m >> (−n). If −n > FRAC, e = 0.
  - Store e in ebuf[idx]; acc += e.
- Completion, at the idx==15 edge:
  - O_EXP ← ebuf, including the final element.
  - O_SUM ← acc + e.
  - O_VLD ← 1.
- O_EXP/O_SUM hold their values until the next completion.
- I_ENA while in S_CALC is ignored. No queueing, no error flag.
- Width rules:
  - e ≤ 1<<FRAC; the sum is ≤ 16<<FRAC, so it fits in D_W+4 bits without saturation.
  - The product is held at D_W+14 bits signed; no truncation before the shift.

## Timing
- Reset values: state S_IDLE; idx 0; acc 0; ebuf, O_EXP all 0; O_SUM 0; O_VLD 0; O_BUSY 0.
- I_ENA accepted at edge E0 → O_BUSY high from E0.
  - Elements 0..15 are evaluated at edges E1..E16.
  - O_VLD is high for exactly the cycle after E16, and O_BUSY is low in that same cycle.
- Latency: 16 clocks from the accepting edge to O_VLD.
- Back-to-back: I_ENA high during the O_VLD cycle is accepted. Minimum row period is 17 clocks, well above the max-select stage's 4.
- Reset mid-row: all state returns to reset values immediately. The partial row is discarded and no O_VLD is produced.
- I_DATA/I_MAX are only sampled at the accepting edge; they may change freely afterwards.

## Structure
- Package mha_pkg holds:
  - LOG2E_Q12 = 5909;
  - EXP2_LUT[0:15] = round(2^(i/16)·32768), 17-bit unsigned: 32768, 34219, 35734, 37316, 38968, 40693, 42495, 44376, 46341, 48393, 50535, 52773, 55109, 57549, 60097, 62757;
  - the state enum typedef.
- Sub-module exp2_unit, combinational: diff in → e out. It contains the clamp, multiply, split, LUT and shift, so it can be unit-tested alone.
- exp_sum holds the FSM, index counter, row latch, ebuf and accumulator.

## Test plan
- All 16 I_DATA = 0x0100, I_MAX = 0x0100 → O_VLD 16 clocks after I_ENA; every O_EXP = 256; O_SUM = 4096.
- I_DATA[0] = 0 = I_MAX, others 0x8000 → O_EXP[0] = 256, O_EXP[1..15] = 0, O_SUM = 256.
- I_DATA[k] = −256 (−1.0) for all k, I_MAX = 0 → trace is t = −370, n = −2, LUT[8] → 362 → every O_EXP = 90, O_SUM = 1440.
- I_DATA[3] = 0x0200, I_MAX = 0x0100 (positive diff) → O_EXP[3] = 256 (clamped).
- Two rows, the second I_ENA in the O_VLD cycle → second O_VLD exactly 17 clocks after the first. An I_ENA pulse mid-row has no effect.
- I_RST_N low at E8 → O_BUSY and O_VLD go to 0 immediately; O_EXP/O_SUM = 0. After release, a fresh row completes normally.
